// File: rtl/md_unit_ctrl_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies and
// sequencer state codes used by the decoder, stall unit and md sequencer.
package md_unit_ctrl_pkg;

    // E_MDOp encodings; 6 and 7 are reserved and never accepted.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Ops 0-3 occupy the multiply/divide resource; bit 2 clear marks them.
    function automatic logic md_is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

    // Divides are ops 2 and 3; bit 1 selects the longer latency.
    function automatic logic md_is_div(input logic [2:0] op);
        return ~op[2] & op[1];
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the {hi, lo} result for
// one md command. A divide by zero returns the current HI/LO unchanged.
module md_arith
    import md_unit_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [63:0] res
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] b_mag_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        div_zero;

    // The low 64 bits of a product of sign-extended operands equal the
    // signed product, so both multiplies share one unsigned operator form.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: truncation toward zero falls out of the
    // unsigned divide, and |0x80000000| = 0x80000000 as an unsigned value,
    // which makes 0x80000000 / -1 yield quotient 0x80000000, remainder 0.
    assign a_neg      = a[31];
    assign b_neg      = b[31];
    assign a_mag      = a_neg ? (32'd0 - a) : a;
    assign b_mag      = b_neg ? (32'd0 - b) : b;
    assign div_zero   = (b == 32'd0);
    assign b_safe     = div_zero ? 32'd1 : b;
    assign b_mag_safe = div_zero ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_mag_safe;
    assign r_mag      = a_mag % b_mag_safe;
    assign q_s        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign r_s        = a_neg ? (32'd0 - r_mag) : r_mag;
    assign q_u        = a / b_safe;
    assign r_u        = a % b_safe;

    // Select the result for the op; divides put remainder in HI, quotient in LO.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        res = {cur_hi, cur_lo};
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV:   res = div_zero ? {cur_hi, cur_lo} : {r_s, q_s};
            MD_DIVU:  res = div_zero ? {cur_hi, cur_lo} : {r_u, q_u};
            default:  res = {cur_hi, cur_lo};
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: accepts md commands from E, models the
// multi-cycle latency with a down counter, commits HI/LO on expiry and
// raises the D-stage stall for instructions that touch HI/LO.
module md_unit_ctrl
    import md_unit_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_Start,
    input  logic [2:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        Req,
    input  logic        D_MDUse,
    output logic        E_Busy,
    output logic        D_MDStall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q;
    md_state_e          state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        pend_hi_q;
    logic [31:0]        pend_lo_q;
    logic [63:0]        arith_res;
    logic               cmd_ok;
    logic               accept_arith;
    logic               accept_mthi;
    logic               accept_mtlo;
    logic               done;

    md_arith u_md_arith (
        .op     (E_MDOp),
        .a      (E_A),
        .b      (E_B),
        .cur_hi (hi_q),
        .cur_lo (lo_q),
        .res    (arith_res)
    );

    // A command is only taken in IDLE and when no flush kills it this cycle.
    assign cmd_ok       = (state_q == ST_IDLE) & E_Start & ~Req;
    assign accept_arith = cmd_ok & md_is_arith(E_MDOp);
    assign accept_mthi  = cmd_ok & (E_MDOp == MD_MTHI);
    assign accept_mtlo  = cmd_ok & (E_MDOp == MD_MTLO);
    assign done         = (state_q == ST_BUSY) & (cnt_q == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: enter BUSY on an arithmetic accept, leave on the last count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_arith) state_d = ST_BUSY;
            ST_BUSY: if (done)         state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Counter, pending result and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            if (accept_arith) begin
                pend_hi_q <= arith_res[63:32];
                pend_lo_q <= arith_res[31:0];
                cnt_q     <= md_is_div(E_MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (done) begin
                hi_q  <= pend_hi_q;
                lo_q  <= pend_lo_q;
                cnt_q <= '0;
            end else if (state_q == ST_BUSY) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (accept_mthi) hi_q <= E_A;
            if (accept_mtlo) lo_q <= E_A;
        end
    end

    // Outputs: busy flag and combinational stall toward the D/E registers.
    always_comb begin
        E_Busy    = (state_q == ST_BUSY);
        D_MDStall = D_MDUse & ((state_q == ST_BUSY) | E_Start);
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: latency, arithmetic corner cases, stall,
// flush handling, mthi/mtlo, divide by zero and asynchronous reset.
module tb_md_unit_ctrl;
    import md_unit_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        E_Start = 1'b0;
    logic [2:0]  E_MDOp = 3'd0;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        Req = 1'b0;
    logic        D_MDUse = 1'b0;
    logic        E_Busy;
    logic        D_MDStall;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    md_unit_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .E_Start   (E_Start),
        .E_MDOp    (E_MDOp),
        .E_A       (E_A),
        .E_B       (E_B),
        .Req       (Req),
        .D_MDUse   (D_MDUse),
        .E_Busy    (E_Busy),
        .D_MDStall (D_MDStall),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    // Issuing a command while busy is illegal; record any occurrence.
    always @(posedge clk) if (reset && E_Busy && E_Start) viol++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a command for one cycle; returns at the negedge after the accepting edge.
    task automatic cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
        @(negedge clk);
        E_Start = 1'b1; E_MDOp = op; E_A = a; E_B = b; Req = req;
        @(negedge clk);
        E_Start = 1'b0; Req = 1'b0;
    endtask

    // Count remaining busy cycles (bounded) until E_Busy drops.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (E_Busy && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int stall_cnt;

        // Reset state
        #1;
        check("rst_busy", E_Busy, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // mult -2 * 3
        cmd(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        wait_idle(cyc);
        check("mult_cyc", cyc, 5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFA);

        // multu same operands
        cmd(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
        wait_idle(cyc);
        check("multu_cyc", cyc, 5);
        check("multu_hi", HI, 32'h00000002);
        check("multu_lo", LO, 32'hFFFFFFFA);

        // Reset asserted mid-operation clears everything without a clock edge
        cmd(MD_DIV, 32'd50, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", E_Busy, 0);
        check("arst_hi", HI, 0);
        check("arst_lo", LO, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("arst_after_busy", E_Busy, 0);
        check("arst_after_lo", LO, 0);

        // div -7 / 2
        cmd(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_idle(cyc);
        check("div_cyc", cyc, 10);
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);

        // div overflow case
        cmd(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle(cyc);
        check("divov_lo", LO, 32'h80000000);
        check("divov_hi", HI, 32'h00000000);

        // divu
        cmd(MD_DIVU, 32'hFFFFFFFF, 32'h10, 1'b0);
        wait_idle(cyc);
        check("divu_lo", LO, 32'h0FFFFFFF);
        check("divu_hi", HI, 32'h0000000F);

        // Stall with D_MDUse=1: E_Start cycle plus every busy cycle
        stall_cnt = 0;
        @(negedge clk);
        D_MDUse = 1'b1; E_Start = 1'b1; E_MDOp = MD_MULT; E_A = 32'd7; E_B = 32'd6;
        #1 if (D_MDStall) stall_cnt++;
        @(negedge clk);
        E_Start = 1'b0;
        cyc = 0;
        while (E_Busy && cyc < 64) begin
            #1 if (D_MDStall) stall_cnt++;
            cyc++;
            @(negedge clk);
        end
        #1;
        check("stall_fall", D_MDStall, 0);
        check("stall_cnt", stall_cnt, 6);
        check("stall_mult_lo", LO, 32'd42);

        // No stall when D_MDUse=0
        stall_cnt = 0;
        @(negedge clk);
        D_MDUse = 1'b0; E_Start = 1'b1; E_MDOp = MD_DIV; E_A = 32'd9; E_B = 32'd4;
        #1 if (D_MDStall) stall_cnt++;
        @(negedge clk);
        E_Start = 1'b0;
        cyc = 0;
        while (E_Busy && cyc < 64) begin
            #1 if (D_MDStall) stall_cnt++;
            cyc++;
            @(negedge clk);
        end
        check("nostall_cnt", stall_cnt, 0);
        check("nostall_cyc", cyc, 10);
        check("nostall_hi", HI, 32'd1);

        // Flush with E_Start drops the command
        cmd(MD_MULT, 32'd100, 32'd100, 1'b1);
        check("req_busy", E_Busy, 0);
        @(negedge clk);
        check("req_hi", HI, 32'd1);
        check("req_lo", LO, 32'd2);

        // Reserved op ignored
        cmd(3'd6, 32'h55, 32'h66, 1'b0);
        check("rsv_busy", E_Busy, 0);
        check("rsv_hi", HI, 32'd1);

        // Flush during in-flight div: completes normally
        cmd(MD_DIV, 32'd100, 32'd7, 1'b0);
        repeat (2) @(negedge clk);
        Req = 1'b1;
        @(negedge clk);
        Req = 1'b0;
        wait_idle(cyc);
        check("reqbusy_cyc", cyc, 7);
        check("reqbusy_lo", LO, 32'd14);
        check("reqbusy_hi", HI, 32'd2);

        // mthi / mtlo
        cmd(MD_MTHI, 32'h12345678, 32'd0, 1'b0);
        check("mthi_busy", E_Busy, 0);
        check("mthi_hi", HI, 32'h12345678);
        check("mthi_lo", LO, 32'd14);
        cmd(MD_MTHI, 32'd1, 32'd0, 1'b0);
        cmd(MD_MTLO, 32'd2, 32'd0, 1'b0);
        check("mtlo_lo", LO, 32'd2);
        check("mtlo_hi", HI, 32'd1);

        // divu by zero keeps HI/LO but still busy for the divide latency
        cmd(MD_DIVU, 32'd5, 32'd0, 1'b0);
        wait_idle(cyc);
        check("dz_cyc", cyc, 10);
        check("dz_hi", HI, 32'd1);
        check("dz_lo", LO, 32'd2);

        check("no_start_while_busy", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
